mult_seq_ctrl: RTL and testbench

Parametrised sequencer for the nibble-serial multiplier: drives a 4x4 multiplier, operand nibble muxes, shifter and accumulator to form a (4·NIBBLES_A)x(4·NIBBLES_B) product one partial product per cycle. It replaces the fixed 8x8 controller and its external 2-bit counter with an internal 2-D nibble counter. It also adds a stall input, a sticky error flag and a busy flag. It sits between the top-level start/done handshake and the datapath.

---
 rtl/mult_seq_pkg.sv | 23 ++
 rtl/nibble_index_counter.sv | 41 ++++
 rtl/mult_seq_ctrl.sv | 92 +++++++++
 tb/tb_mult_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: state encoding and width helper shared by the multiplier sequencer
package mult_seq_pkg;

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_CLEAR = 3'b001;
    localparam logic [2:0] S_ACCUM = 3'b010;
    localparam logic [2:0] S_DONE  = 3'b011;
    localparam logic [2:0] S_ERR   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_CLEAR = S_CLEAR,
        ST_ACCUM = S_ACCUM,
        ST_DONE  = S_DONE,
        ST_ERR   = S_ERR
    } state_t;

    // clog2 clamped to at least one bit so single-nibble operands still get a select port
    function automatic int clog2c(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_index_counter.sv
// nibble_index_counter: 2-D wrap counter, idx_a inner and idx_b outer
module nibble_index_counter
    import mult_seq_pkg::*;
#(
    parameter int NA = 2,
    parameter int NB = 2,
    localparam int AW = clog2c(NA),
    localparam int BW = clog2c(NB)
) (
    input  logic          clk,
    input  logic          reset_a,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] idx_a,
    output logic [BW-1:0] idx_b,
    output logic          last
);

    localparam logic [AW-1:0] A_MAX = AW'(NA - 1);
    localparam logic [BW-1:0] B_MAX = BW'(NB - 1);

    logic wrap_a;

    assign wrap_a = idx_a == A_MAX;
    assign last   = wrap_a && idx_b == B_MAX;

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            idx_a <= '0;
            idx_b <= '0;
        end else if (clr) begin
            idx_a <= '0;
            idx_b <= '0;
        end else if (en) begin
            idx_a <= wrap_a ? '0 : idx_a + 1'b1;
            if (wrap_a)
                idx_b <= (idx_b == B_MAX) ? '0 : idx_b + 1'b1;
        end
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencer forming a nibble-serial product, one partial product per cycle
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int NIBBLES_A = 2,
    parameter int NIBBLES_B = 2,
    localparam int AW = clog2c(NIBBLES_A),
    localparam int BW = clog2c(NIBBLES_B),
    localparam int SW = clog2c(NIBBLES_A + NIBBLES_B - 1)
) (
    input  logic          clk,
    input  logic          reset_a,
    input  logic          start,
    input  logic          stall,
    output logic [AW-1:0] sel_a,
    output logic [BW-1:0] sel_b,
    output logic [SW-1:0] shift_sel,
    output logic          clk_ena,
    output logic          sclr_n,
    output logic          done,
    output logic          busy,
    output logic          err,
    output logic [2:0]    state_out
);

    state_t        state, state_nxt;
    logic [AW-1:0] idx_a;
    logic [BW-1:0] idx_b;
    logic          last;
    logic          in_accum;

    assign in_accum = state == ST_ACCUM;

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    nibble_index_counter #(
        .NA(NIBBLES_A),
        .NB(NIBBLES_B)
    ) u_cnt (
        .clk    (clk),
        .reset_a(reset_a),
        .clr    (state == ST_CLEAR),
        .en     (in_accum && !stall),
        .idx_a  (idx_a),
        .idx_b  (idx_b),
        .last   (last)
    );

    // A start outside IDLE/ERR is a protocol violation and wins over advancing
    always_comb begin
        state_nxt = ST_IDLE;
        clk_ena   = 1'b0;
        sclr_n    = 1'b1;
        done      = 1'b0;
        busy      = 1'b0;
        err       = 1'b0;
        case (state)
            ST_IDLE:  state_nxt = start ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: begin
                sclr_n    = 1'b0;
                clk_ena   = 1'b1;
                busy      = 1'b1;
                state_nxt = start ? ST_ERR : ST_ACCUM;
            end
            ST_ACCUM: begin
                clk_ena   = !stall;
                busy      = 1'b1;
                state_nxt = start ? ST_ERR : (!stall && last) ? ST_DONE : ST_ACCUM;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = start ? ST_ERR : ST_IDLE;
            end
            ST_ERR: begin
                err       = 1'b1;
                state_nxt = start ? ST_CLEAR : ST_ERR;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign sel_a     = in_accum ? idx_a : '0;
    assign sel_b     = in_accum ? idx_b : '0;
    assign shift_sel = in_accum ? SW'(idx_a) + SW'(idx_b) : '0;
    assign state_out = state;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: scoreboard bench for a 2x2-nibble and a 4x2-nibble sequencer
module tb_mult_seq_ctrl;
    import mult_seq_pkg::*;

    logic clk = 1'b0, reset_a = 1'b1, start2 = 1'b0, start4 = 1'b0, stall = 1'b0;

    logic [0:0] sel_a2, sel_b2;
    logic [1:0] shift2;
    logic       clk_ena2, sclr_n2, done2, busy2, err2;
    logic [2:0] state2;

    logic [1:0] sel_a4;
    logic [0:0] sel_b4;
    logic [2:0] shift4;
    logic       clk_ena4, sclr_n4, done4, busy4, err4;
    logic [2:0] state4;

    logic [7:0]  a2, b2, b4;
    logic [15:0] a4;
    logic [31:0] acc2, acc4;
    logic [31:0] q2[$], q4[$];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.NIBBLES_A(2), .NIBBLES_B(2)) dut2 (
        .clk(clk), .reset_a(reset_a), .start(start2), .stall(stall),
        .sel_a(sel_a2), .sel_b(sel_b2), .shift_sel(shift2),
        .clk_ena(clk_ena2), .sclr_n(sclr_n2), .done(done2), .busy(busy2),
        .err(err2), .state_out(state2)
    );

    mult_seq_ctrl #(.NIBBLES_A(4), .NIBBLES_B(2)) dut4 (
        .clk(clk), .reset_a(reset_a), .start(start4), .stall(1'b0),
        .sel_a(sel_a4), .sel_b(sel_b4), .shift_sel(shift4),
        .clk_ena(clk_ena4), .sclr_n(sclr_n4), .done(done4), .busy(busy4),
        .err(err4), .state_out(state4)
    );

    // behavioural nibble datapath driven by the sequencer outputs
    always @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            acc2 <= '0;
            acc4 <= '0;
        end else begin
            if (!sclr_n2) acc2 <= '0;
            else if (clk_ena2) acc2 <= acc2 + ((32'(a2[4*sel_a2 +: 4]) * 32'(b2[4*sel_b2 +: 4])) << (4*shift2));
            if (!sclr_n4) acc4 <= '0;
            else if (clk_ena4) acc4 <= acc4 + ((32'(a4[4*sel_a4 +: 4]) * 32'(b4[4*sel_b4 +: 4])) << (4*shift4));
        end
    end

    task automatic test_reset;
        #1 reset_a = 1'b0;
        #1;
        tests++; if (state2 !== S_IDLE || state4 !== S_IDLE) begin fails++; $display("FAIL reset_state: got %0d/%0d want 0", state2, state4); end
        tests++; if ({done2, clk_ena2, sclr_n2, busy2, err2} !== 5'b00100) begin fails++; $display("FAIL reset_outs2: got %b want 00100", {done2, clk_ena2, sclr_n2, busy2, err2}); end
        tests++; if ({done4, clk_ena4, sclr_n4, busy4, err4} !== 5'b00100) begin fails++; $display("FAIL reset_outs4: got %b want 00100", {done4, clk_ena4, sclr_n4, busy4, err4}); end
        tests++; if ({sel_a2, sel_b2, shift2, sel_a4, sel_b4, shift4} !== 10'd0) begin fails++; $display("FAIL reset_sel: got %b want 0", {sel_a2, sel_b2, shift2, sel_a4, sel_b4, shift4}); end
        repeat (2) @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
    endtask

    task automatic run2(input logic [7:0] a, input logic [7:0] b);
        logic [0:0] ea, eb;
        logic [1:0] es;
        logic [31:0] exp;
        a2 = a; b2 = b;
        q2.push_back(32'(a) * 32'(b));
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        tests++; if (state2 !== S_CLEAR || sclr_n2 !== 1'b0 || clk_ena2 !== 1'b1 || busy2 !== 1'b1) begin fails++; $display("FAIL run2_clear: got st=%0d sclr_n=%b ena=%b busy=%b want 1/0/1/1", state2, sclr_n2, clk_ena2, busy2); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ea = 1'(i % 2); eb = 1'(i / 2); es = 2'(i % 2 + i / 2);
            tests++; if (state2 !== S_ACCUM || {sel_a2, sel_b2, shift2} !== {ea, eb, es} || clk_ena2 !== 1'b1 || sclr_n2 !== 1'b1) begin fails++; $display("FAIL run2_accum%0d: got st=%0d sel=(%0d,%0d,%0d) ena=%b want 2 (%0d,%0d,%0d) 1", i, state2, sel_a2, sel_b2, shift2, clk_ena2, ea, eb, es); end
        end
        @(negedge clk);
        tests++; if (done2 !== 1'b1 || state2 !== S_DONE || clk_ena2 !== 1'b0) begin fails++; $display("FAIL run2_done: got done=%b st=%0d ena=%b want 1/3/0", done2, state2, clk_ena2); end
        exp = (q2.size() != 0) ? q2.pop_front() : 32'hDEAD_BEEF;
        tests++; if (acc2 !== exp) begin fails++; $display("FAIL run2_product: got %h want %h", acc2, exp); end
        @(negedge clk);
        tests++; if (state2 !== S_IDLE || done2 !== 1'b0 || busy2 !== 1'b0) begin fails++; $display("FAIL run2_idle: got st=%0d done=%b busy=%b want 0/0/0", state2, done2, busy2); end
    endtask

    task automatic run4(input logic [15:0] a, input logic [7:0] b);
        logic [1:0] ea;
        logic [0:0] eb;
        logic [2:0] es, smax;
        logic [31:0] exp;
        a4 = a; b4 = b; smax = '0;
        q4.push_back(32'(a) * 32'(b));
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        tests++; if (state4 !== S_CLEAR || sclr_n4 !== 1'b0) begin fails++; $display("FAIL run4_clear: got st=%0d sclr_n=%b want 1/0", state4, sclr_n4); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ea = 2'(i % 4); eb = 1'(i / 4); es = 3'(i % 4 + i / 4);
            if (shift4 > smax) smax = shift4;
            tests++; if (state4 !== S_ACCUM || {sel_a4, sel_b4, shift4} !== {ea, eb, es}) begin fails++; $display("FAIL run4_accum%0d: got st=%0d sel=(%0d,%0d,%0d) want 2 (%0d,%0d,%0d)", i, state4, sel_a4, sel_b4, shift4, ea, eb, es); end
        end
        tests++; if (smax !== 3'd4) begin fails++; $display("FAIL run4_shift_peak: got %0d want 4", smax); end
        @(negedge clk);
        tests++; if (done4 !== 1'b1 || state4 !== S_DONE) begin fails++; $display("FAIL run4_done: got done=%b st=%0d want 1/3", done4, state4); end
        exp = (q4.size() != 0) ? q4.pop_front() : 32'hDEAD_BEEF;
        tests++; if (acc4 !== exp) begin fails++; $display("FAIL run4_product: got %h want %h", acc4, exp); end
        @(negedge clk);
        tests++; if (state4 !== S_IDLE || done4 !== 1'b0) begin fails++; $display("FAIL run4_idle: got st=%0d done=%b want 0/0", state4, done4); end
    endtask

    task automatic test_basic;
        run2(8'hFF, 8'hFF);
        run4(16'hFFFF, 8'hFF);
    endtask

    task automatic test_back_to_back;
        run2(8'h12, 8'h34);
        run2(8'h9C, 8'hE7);
        run4(16'hBEEF, 8'h5A);
    endtask

    task automatic test_stall;
        logic [31:0] exp;
        a2 = 8'hA7; b2 = 8'h3C;
        q2.push_back(32'(a2) * 32'(b2));
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if ({sel_a2, sel_b2} !== 2'b10) begin fails++; $display("FAIL stall_pos: got (%0d,%0d) want (1,0)", sel_a2, sel_b2); end
        stall = 1'b1;
        #1;
        tests++; if (clk_ena2 !== 1'b0) begin fails++; $display("FAIL stall_ena: got %b want 0", clk_ena2); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if ({sel_a2, sel_b2, shift2} !== 4'b1001 || clk_ena2 !== 1'b0 || state2 !== S_ACCUM || done2 !== 1'b0) begin fails++; $display("FAIL stall_frozen%0d: got sel=(%0d,%0d,%0d) ena=%b st=%0d want (1,0,1) 0 2", i, sel_a2, sel_b2, shift2, clk_ena2, state2); end
        end
        stall = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (done2 !== 1'b1) begin fails++; $display("FAIL stall_done_late: got done=%b want 1", done2); end
        exp = (q2.size() != 0) ? q2.pop_front() : 32'hDEAD_BEEF;
        tests++; if (acc2 !== exp) begin fails++; $display("FAIL stall_product: got %h want %h", acc2, exp); end
        @(negedge clk);
    endtask

    task automatic test_err_accum;
        a2 = 8'h77; b2 = 8'h88;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if ({sel_a2, sel_b2} !== 2'b01) begin fails++; $display("FAIL err_pos: got (%0d,%0d) want (0,1)", sel_a2, sel_b2); end
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        tests++; if (state2 !== S_ERR || err2 !== 1'b1 || clk_ena2 !== 1'b0 || sclr_n2 !== 1'b1 || busy2 !== 1'b0) begin fails++; $display("FAIL err_enter: got st=%0d err=%b ena=%b sclr_n=%b busy=%b want 4/1/0/1/0", state2, err2, clk_ena2, sclr_n2, busy2); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (done2 !== 1'b0 || state2 !== S_ERR || {sel_a2, sel_b2, shift2} !== 4'd0) begin fails++; $display("FAIL err_sticky%0d: got done=%b st=%0d sel=%b want 0/4/0", i, done2, state2, {sel_a2, sel_b2, shift2}); end
            @(negedge clk);
        end
        run2(8'h5A, 8'hC3);
    endtask

    task automatic test_err_done;
        logic [31:0] exp;
        a2 = 8'h3F; b2 = 8'hD2;
        q2.push_back(32'(a2) * 32'(b2));
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (5) @(negedge clk);
        tests++; if (done2 !== 1'b1) begin fails++; $display("FAIL errdone_done: got %b want 1", done2); end
        exp = (q2.size() != 0) ? q2.pop_front() : 32'hDEAD_BEEF;
        tests++; if (acc2 !== exp) begin fails++; $display("FAIL errdone_product: got %h want %h", acc2, exp); end
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        tests++; if (state2 !== S_ERR || err2 !== 1'b1 || done2 !== 1'b0) begin fails++; $display("FAIL errdone_err: got st=%0d err=%b done=%b want 4/1/0", state2, err2, done2); end
        run2(8'h01, 8'hFF);
    endtask

    task automatic test_reset_mid;
        a4 = 16'h1234; b4 = 8'h56;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_a = 1'b0;
        #1;
        tests++; if (state4 !== S_IDLE || {done4, clk_ena4, sclr_n4, busy4, err4} !== 5'b00100 || {sel_a4, sel_b4, shift4} !== 6'd0) begin fails++; $display("FAIL rstmid_async: got st=%0d outs=%b sel=%b want 0 00100 0", state4, {done4, clk_ena4, sclr_n4, busy4, err4}, {sel_a4, sel_b4, shift4}); end
        @(negedge clk);
        reset_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++; if (done4 !== 1'b0 || state4 !== S_IDLE) begin fails++; $display("FAIL rstmid_quiet%0d: got done=%b st=%0d want 0/0", i, done4, state4); end
        end
        run4(16'hFFFF, 8'hFF);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_stall;
        test_err_accum;
        test_err_done;
        test_reset_mid;
        tests++; if (q2.size() != 0 || q4.size() != 0) begin fails++; $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", q2.size(), q4.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
